// File: rtl/register_bank_mp.sv
// register_bank_mp
// Multi-read-port register bank for the RISC datapath. Decode reads operands
// and marks destination registers busy; writeback writes results and clears
// the busy mark. Reads are combinational with optional write-through bypass.
//
// Parameters:
//   DATA_W   register width
//   ADDR_W   address width, depth = 2**ADDR_W
//   NUM_RD   number of read ports (1..4)
//   ZERO_REG 1 = register 0 is hardwired to zero and never busy
//   BYPASS   1 = a read of the register being written returns the write data
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-low reset (clears data and busy bits)
//   regWriteEnable write strobe
//   regWriteAddr   write address
//   regWriteData   write data
//   busySet        mark busyAddr as having an outstanding write
//   busyAddr       register to mark busy
//   regAddr        packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   regReadData    packed read data, port k at [k*DATA_W +: DATA_W]
//   regBusy        busy flag of each port's addressed register
//   anyBusy        OR of all busy bits
module register_bank_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     regWriteEnable,
  input  logic [ADDR_W-1:0]        regWriteAddr,
  input  logic [DATA_W-1:0]        regWriteData,
  input  logic                     busySet,
  input  logic [ADDR_W-1:0]        busyAddr,
  input  logic [NUM_RD*ADDR_W-1:0] regAddr,
  output logic [NUM_RD*DATA_W-1:0] regReadData,
  output logic [NUM_RD-1:0]        regBusy,
  output logic                     anyBusy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic              wr_en;
  logic              bs_en;

  // Qualify write and busy-set strobes: register 0 swallows both when hardwired.
  always_comb begin
    if ((ZERO_REG != 0) && (regWriteAddr == '0)) begin
      wr_en = 1'b0;
    end else begin
      wr_en = regWriteEnable;
    end
    if ((ZERO_REG != 0) && (busyAddr == '0)) begin
      bs_en = 1'b0;
    end else begin
      bs_en = busySet;
    end
  end

  // Next-state for data and scoreboard. busySet is applied after the write's
  // clear so that a new producer issued on the same edge keeps the register busy.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    if (wr_en) begin
      mem_d[regWriteAddr]  = regWriteData;
      busy_d[regWriteAddr] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (bs_en) begin
      busy_d[busyAddr] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
  end

  // State registers with asynchronous clear of every register and busy bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] rd_addr;
    logic              bypass_hit;
    logic [DATA_W-1:0] rd_data;
    logic              rd_busy;

    assign rd_addr = regAddr[k*ADDR_W +: ADDR_W];

    // wr_en already excludes register 0; a same-cycle busySet on the address
    // means a newer producer exists, so the write data is not forwarded.
    assign bypass_hit = (BYPASS != 0) && wr_en && (regWriteAddr == rd_addr) &&
                        !(bs_en && (busyAddr == rd_addr));

    // Read mux: forced zero in reset, then bypass, then stored contents.
    always_comb begin
      if (!rst) begin
        rd_data = '0;
        rd_busy = 1'b0;
      end else if (bypass_hit) begin
        rd_data = regWriteData;
        rd_busy = 1'b0;
      end else begin
        rd_data = mem_q[rd_addr];
        rd_busy = busy_q[rd_addr];
      end
    end

    assign regReadData[k*DATA_W +: DATA_W] = rd_data;
    assign regBusy[k]                      = rd_busy;
  end

  // Bypass masking deliberately not applied here: decode sees the raw scoreboard.
  assign anyBusy = |busy_q;

endmodule

// File: tb/tb_register_bank_mp.sv
module tb_register_bank_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  // shared write side for the two 32-bit instances
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        bs;
  logic [4:0]  ba;
  logic [9:0]  ra;
  logic [63:0] rd0;
  logic [1:0]  rb0;
  logic        any0;
  logic [31:0] rd1;
  logic [0:0]  rb1;
  logic        any1;
  // 16-bit, 8-deep, 3-port instance
  logic        we2;
  logic [2:0]  wa2;
  logic [15:0] wd2;
  logic        bs2;
  logic [2:0]  ba2;
  logic [8:0]  ra2;
  logic [47:0] rd2;
  logic [2:0]  rb2;
  logic        any2;

  register_bank_mp u0 (
    .clk(clk), .rst(rst), .regWriteEnable(we), .regWriteAddr(wa), .regWriteData(wd),
    .busySet(bs), .busyAddr(ba), .regAddr(ra), .regReadData(rd0), .regBusy(rb0), .anyBusy(any0)
  );

  register_bank_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(1), .ZERO_REG(0), .BYPASS(0)) u1 (
    .clk(clk), .rst(rst), .regWriteEnable(we), .regWriteAddr(wa), .regWriteData(wd),
    .busySet(bs), .busyAddr(ba), .regAddr(ra[4:0]), .regReadData(rd1), .regBusy(rb1), .anyBusy(any1)
  );

  register_bank_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(3)) u2 (
    .clk(clk), .rst(rst), .regWriteEnable(we2), .regWriteAddr(wa2), .regWriteData(wd2),
    .busySet(bs2), .busyAddr(ba2), .regAddr(ra2), .regReadData(rd2), .regBusy(rb2), .anyBusy(any2)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        bs;
    logic [4:0]  ba;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  eb;
    logic        eany;
    logic [31:0] en;
    logic        enb;
    logic        enany;
  } vec_t;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  vec_t tbl[18];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic w, input logic [4:0] a, input logic [31:0] d,
                              input logic s, input logic [4:0] b,
                              input logic [4:0] r0, input logic [4:0] r1,
                              input logic [31:0] e0, input logic [31:0] e1,
                              input logic [1:0] eb, input logic eany,
                              input logic [31:0] en, input logic enb, input logic enany);
    vec_t v;
    v.we = w; v.wa = a; v.wd = d; v.bs = s; v.ba = b; v.r0 = r0; v.r1 = r1;
    v.e0 = e0; v.e1 = e1; v.eb = eb; v.eany = eany; v.en = en; v.enb = enb; v.enany = enany;
    return v;
  endfunction

  task automatic push(input string t, input logic [63:0] v);
    exp_t e;
    e.tag = t;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [63:0] act);
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty: got %h, nothing expected", act);
    end else begin
      e = sb.pop_front();
      if (act !== e.val) begin
        n_bad++;
        $display("FAIL %s: got %h, expected %h", e.tag, act, e.val);
      end
    end
  endtask

  function automatic logic [15:0] u2_val(input int i);
    return (i == 0) ? 16'h0000 : (16'h1000 + 16'(i));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; we = 1'b0; wa = 5'd0; wd = 32'd0; bs = 1'b0; ba = 5'd0; ra = 10'd0;
    we2 = 1'b0; wa2 = 3'd0; wd2 = 16'd0; bs2 = 1'b0; ba2 = 3'd0; ra2 = 9'd0;

    //            we  wa  wd              bs  ba   r0  r1  e0              e1              eb     eany  en              enb   enany
    tbl[0]  = mk(1'b1, 5'd28, 32'd143434,     1'b0, 5'd0,  5'd28, 5'd30, 32'd143434,     32'd0,          2'b00, 1'b0, 32'd0,          1'b0, 1'b0);
    tbl[1]  = mk(1'b1, 5'd30, 32'd7,          1'b0, 5'd0,  5'd28, 5'd30, 32'd143434,     32'd7,          2'b00, 1'b0, 32'd143434,     1'b0, 1'b0);
    tbl[2]  = mk(1'b0, 5'd0,  32'd0,          1'b0, 5'd0,  5'd30, 5'd28, 32'd7,          32'd143434,     2'b00, 1'b0, 32'd7,          1'b0, 1'b0);
    tbl[3]  = mk(1'b0, 5'd30, 32'd5,          1'b0, 5'd0,  5'd30, 5'd28, 32'd7,          32'd143434,     2'b00, 1'b0, 32'd7,          1'b0, 1'b0);
    tbl[4]  = mk(1'b1, 5'd5,  32'hDEAD_BEEF,  1'b0, 5'd0,  5'd5,  5'd5,  32'hDEAD_BEEF,  32'hDEAD_BEEF,  2'b00, 1'b0, 32'd0,          1'b0, 1'b0);
    tbl[5]  = mk(1'b1, 5'd0,  32'hFFFF_FFFF,  1'b1, 5'd0,  5'd0,  5'd0,  32'd0,          32'd0,          2'b00, 1'b0, 32'd0,          1'b0, 1'b0);
    tbl[6]  = mk(1'b0, 5'd0,  32'd0,          1'b0, 5'd0,  5'd0,  5'd5,  32'd0,          32'hDEAD_BEEF,  2'b00, 1'b0, 32'hFFFF_FFFF,  1'b1, 1'b1);
    tbl[7]  = mk(1'b0, 5'd0,  32'd0,          1'b1, 5'd12, 5'd12, 5'd12, 32'd0,          32'd0,          2'b00, 1'b0, 32'd0,          1'b0, 1'b1);
    tbl[8]  = mk(1'b0, 5'd0,  32'd0,          1'b0, 5'd0,  5'd12, 5'd5,  32'd0,          32'hDEAD_BEEF,  2'b01, 1'b1, 32'd0,          1'b1, 1'b1);
    tbl[9]  = mk(1'b1, 5'd12, 32'd99,         1'b0, 5'd0,  5'd12, 5'd13, 32'd99,         32'd0,          2'b00, 1'b1, 32'd0,          1'b1, 1'b1);
    tbl[10] = mk(1'b0, 5'd0,  32'd0,          1'b0, 5'd0,  5'd12, 5'd12, 32'd99,         32'd99,         2'b00, 1'b0, 32'd99,         1'b0, 1'b1);
    tbl[11] = mk(1'b1, 5'd12, 32'd100,        1'b1, 5'd12, 5'd12, 5'd12, 32'd99,         32'd99,         2'b00, 1'b0, 32'd99,         1'b0, 1'b1);
    tbl[12] = mk(1'b0, 5'd0,  32'd0,          1'b0, 5'd0,  5'd12, 5'd12, 32'd100,        32'd100,        2'b11, 1'b1, 32'd100,        1'b1, 1'b1);
    tbl[13] = mk(1'b1, 5'd20, 32'd55,         1'b1, 5'd21, 5'd20, 5'd21, 32'd55,         32'd0,          2'b00, 1'b1, 32'd0,          1'b0, 1'b1);
    tbl[14] = mk(1'b0, 5'd0,  32'd0,          1'b0, 5'd0,  5'd20, 5'd21, 32'd55,         32'd0,          2'b10, 1'b1, 32'd55,         1'b0, 1'b1);
    tbl[15] = mk(1'b1, 5'd12, 32'd7,          1'b0, 5'd0,  5'd21, 5'd12, 32'd0,          32'd7,          2'b01, 1'b1, 32'd0,          1'b1, 1'b1);
    tbl[16] = mk(1'b1, 5'd21, 32'd8,          1'b0, 5'd0,  5'd21, 5'd12, 32'd8,          32'd7,          2'b00, 1'b1, 32'd0,          1'b1, 1'b1);
    tbl[17] = mk(1'b0, 5'd0,  32'd0,          1'b0, 5'd0,  5'd21, 5'd12, 32'd8,          32'd7,          2'b00, 1'b0, 32'd8,          1'b0, 1'b1);

    // reset state, then release mid-cycle
    repeat (2) @(posedge clk);
    @(negedge clk);
    push("reset_rd0", 64'd0);   chk(rd0);
    push("reset_any0", 64'd0);  chk({63'd0, any0});
    push("reset_rd2", 64'd0);   chk({16'd0, rd2});
    rst = 1'b1;

    // table-driven main sequence: outputs sampled mid-cycle, before the commit edge
    for (int i = 0; i < 18; i++) begin
      @(posedge clk);
      #1;
      we = tbl[i].we; wa = tbl[i].wa; wd = tbl[i].wd; bs = tbl[i].bs; ba = tbl[i].ba;
      ra = {tbl[i].r1, tbl[i].r0};
      push($sformatf("v%0d_u0_data", i), {tbl[i].e1, tbl[i].e0});
      push($sformatf("v%0d_u0_busy", i), {62'd0, tbl[i].eb});
      push($sformatf("v%0d_u0_any", i),  {63'd0, tbl[i].eany});
      push($sformatf("v%0d_u1_data", i), {32'd0, tbl[i].en});
      push($sformatf("v%0d_u1_busy", i), {63'd0, tbl[i].enb});
      push($sformatf("v%0d_u1_any", i),  {63'd0, tbl[i].enany});
      @(negedge clk);
      chk(rd0);
      chk({62'd0, rb0});
      chk({63'd0, any0});
      chk({32'd0, rd1});
      chk({63'd0, rb1});
      chk({63'd0, any1});
    end

    // asynchronous reset in the middle of a cycle
    @(posedge clk);
    #1;
    we = 1'b1; wa = 5'd28; wd = 32'h0002_304A; bs = 1'b1; ba = 5'd9; ra = {5'd28, 5'd28};
    @(posedge clk);
    #1;
    we = 1'b0; bs = 1'b0;
    #1;
    push("pre_rst_data", 64'h0000_0000_0002_304A); chk({32'd0, rd0[31:0]});
    push("pre_rst_any", 64'd1);                     chk({63'd0, any0});
    #1;
    rst = 1'b0;
    #1;
    push("async_rst_data0", 64'd0); chk({32'd0, rd0[31:0]});
    push("async_rst_any0", 64'd0);  chk({63'd0, any0});
    push("async_rst_data1", 64'd0); chk({32'd0, rd1});
    push("async_rst_any1", 64'd0);  chk({63'd0, any1});
    // a write presented during reset must neither bypass nor land
    we = 1'b1; wa = 5'd3; wd = 32'd1; bs = 1'b1; ba = 5'd3; ra = {5'd28, 5'd3};
    #1;
    push("rst_no_bypass", 64'd0); chk({32'd0, rd0[31:0]});
    @(negedge clk);
    rst = 1'b1;
    we = 1'b0; bs = 1'b0;
    @(posedge clk);
    #1;
    push("post_rst_reg3", 64'd0);   chk(rd0);
    push("post_rst_busy", 64'd0);   chk({62'd0, rb0});

    // 3-port, 16-bit, 8-deep configuration
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      we2 = 1'b1; wa2 = 3'(i); wd2 = 16'h1000 + 16'(i);
    end
    @(posedge clk);
    #1;
    we2 = 1'b0;
    for (int j = 0; j < 8; j++) begin
      ra2 = {3'((j + 5) % 8), 3'((j + 3) % 8), 3'(j)};
      push($sformatf("u2_read_%0d", j), {16'd0, u2_val((j + 5) % 8), u2_val((j + 3) % 8), u2_val(j)});
      #1;
      chk({16'd0, rd2});
    end
    push("u2_busy", 64'd0); chk({61'd0, rb2});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/register_bank_mp.md
Name: register_bank_mp

Overview:
- Parametrised multi-read-port register bank for the RISC datapath.
- Generalises the current two-read/one-write bank:
  - configurable width, depth and read-port count
  - explicit write address
  - optional hardwired zero register
  - write-through bypass
  - per-register busy scoreboard, so decode can stall on registers with an outstanding write
- Sits between decode (reads, busy set) and writeback (write, busy clear).

Parameters:
- DATA_W, 32: register width in bits.
- ADDR_W, 5: address width; depth = 2**ADDR_W.
- NUM_RD, 2: number of read ports (1..4).
- ZERO_REG, 1: 1 = register 0 reads 0, ignores writes and never becomes busy.
- BYPASS, 1: 1 = a read of the address being written this cycle returns the write data.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- regWriteEnable  in  1  write strobe
- regWriteAddr  in  ADDR_W  write address
- regWriteData  in  DATA_W  write data
- busySet  in  1  mark a register as having a pending write
- busyAddr  in  ADDR_W  register to mark busy
- regAddr  in  NUM_RD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- regReadData  out  NUM_RD*DATA_W  packed read data; port k uses bits [k*DATA_W +: DATA_W]
- regBusy  out  NUM_RD  busy flag of each read port's addressed register
- anyBusy  out  1  OR of all busy bits

Behaviour:
- Reset (rst=0, asynchronous):
  - all 2**ADDR_W registers clear to 0 and all busy bits clear to 0 immediately, without waiting for clk
  - outputs follow combinationally: regReadData = 0, regBusy = 0, anyBusy = 0
  - writes and busySet are ignored while rst=0
  - deassertion is sampled at the next rising edge
- Write:
  - on a rising edge with regWriteEnable=1, mem[regWriteAddr] <= regWriteData
  - the same edge clears busy[regWriteAddr]
- Busy set:
  - on a rising edge with busySet=1, busy[busyAddr] <= 1
- Simultaneous events on one edge:
  - write and busySet on the same address: busy ends at 1 (a new producer has issued). Data is still written.
  - write and busySet on different addresses: both take effect.
- Zero register (ZERO_REG=1):
  - writes to address 0 are discarded
  - busySet to address 0 is discarded
  - port reads of address 0 return 0 with regBusy=0, including under bypass
- Read: combinational, zero latency.
  - Base value: regReadData[k] = mem[regAddr[k]].
  - BYPASS=1: if regWriteEnable=1 and regWriteAddr equals regAddr[k] (not address 0 when ZERO_REG=1), return regWriteData and report regBusy[k]=0. This is not applied when busySet is also active for the same address that cycle.
  - BYPASS=0: the read returns the old value until after the edge.
- regBusy[k] = busy[regAddr[k]], subject to the bypass and zero-register rules above.
- anyBusy is the OR of the busy vector; it does not include bypass masking.
- Multiple ports addressing the same register all return identical data.
- Addresses are always in range, since depth = 2**ADDR_W; there is no wrap or error case.
- Reset mid-operation: a write or busySet in the same cycle as rst falling is lost. Registers read 0 afterwards.
- Implementation:
  - mem as reg array; busy as 2**ADDR_W-bit vector
  - read ports built with generate loop
  - no latches

Test Plan:
- Reset:
  - write 32'h0002_304A to reg 28 (regWriteAddr=28), then pull rst=0 mid-cycle
  - required: regReadData for port0 addr 28 is 0 immediately, before any clk edge; anyBusy=0.
- Write/read, two ports:
  - write 143434 to reg 28 and 7 to reg 30 on consecutive edges; then regAddr = {30, 28}
  - required: port0 = 143434, port1 = 7; with regWriteEnable=0 the contents are unchanged.
- Bypass:
  - BYPASS=1: drive write 0xDEADBEEF to reg 5 with port0 addr 5, checked before the edge
  - required: port0 = 0xDEADBEEF, regBusy[0]=0
  - repeat with BYPASS=0: port0 shows the old value before the edge and 0xDEADBEEF after it.
- Zero register:
  - write 0xFFFFFFFF and busySet to reg 0
  - required: port0 addr 0 reads 0, regBusy[0]=0, anyBusy=0
  - ZERO_REG=0 build: reads 0xFFFFFFFF.
- Scoreboard:
  - busySet reg 12 -> next cycle regBusy=1 and anyBusy=1
  - write reg 12 = 99 -> after the edge regBusy=0 and data reads 99
  - busySet and write to reg 12 on the same edge -> busy remains 1.
- Parametrisation:
  - NUM_RD=3, DATA_W=16, ADDR_W=3; all three ports read 8 distinct registers
  - required: each port returns the matching written value (e.g. reg i = 16'h1000+i).
